// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - registered program-address sequencer with jump, inc and debounced switch wait
module program_sequencer #(
    parameter int P_SIZE   = 5,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              jump,
    input  logic [P_SIZE-1:0] jumpTarget,
    input  logic              waitSwitch,
    input  logic              switchIn,
    output logic [P_SIZE-1:0] addressOut,
    output logic              stalled,
    output logic              switchLevel
);

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);

    state_t            state;
    state_t            next_state;
    logic [P_SIZE-1:0] next_addr;

    logic              sync_q1;
    logic              sync_q2;
    logic [7:0]        deb_cnt;

    // Two-flop synchroniser: switchIn is asynchronous, only sync_q2 is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= switchIn;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: the filtered level only follows sync_q2 after it has disagreed
    // for DEBOUNCE consecutive edges; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt     <= 8'd0;
            switchLevel <= 1'b0;
        end else if (sync_q2 == switchLevel) begin
            deb_cnt <= 8'd0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt     <= 8'd0;
            switchLevel <= sync_q2;
        end else begin
            deb_cnt <= deb_cnt + 8'd1;
        end
    end

    // Next-state / next-address logic. Requests are only honoured in RUN,
    // with fixed priority jump > waitSwitch > inc.
    always_comb begin
        next_state = ST_RUN;
        next_addr  = addressOut;
        case (state)
            ST_RUN: begin
                if (jump) begin
                    next_addr = jumpTarget;
                end else if (waitSwitch) begin
                    next_state = ST_WAIT_PRESS;
                end else if (inc) begin
                    next_addr = addressOut + P_SIZE'(1);
                end
            end
            ST_WAIT_PRESS: begin
                next_state = switchLevel ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
            end
            ST_WAIT_RELEASE: begin
                if (!switchLevel) begin
                    next_addr = addressOut + P_SIZE'(1);
                end else begin
                    next_state = ST_WAIT_RELEASE;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    // stalled is registered from next_state so it changes on the same edge
    // that enters or leaves the wait states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            addressOut <= '0;
            stalled    <= 1'b0;
        end else begin
            state      <= next_state;
            addressOut <= next_addr;
            stalled    <= (next_state != ST_RUN);
        end
    end

endmodule
